// File: rtl/ring_osc.sv
// rtl/ring_osc.sv - behavioural ring oscillator clock source with clk-domain kill and edge counter
//
// Purpose:
//   Simulation model of an odd-length inverter ring. The ring is gated by en and by a
//   synchronous kill register. A clk-domain side synchronises clk_out and counts its
//   rising edges for frequency checks. Ideal period is 2*NO_STAGES*INV_DELAY_ns.
//
// Ports:
//   clk      in   1      reference clock for kill register, synchroniser and counter
//   rst      in   1      synchronous active-high reset, sampled on posedge clk
//   en       in   1      asynchronous ring enable (1 = oscillate, 0 = stop)
//   clk_out  out  1      ring oscillator output
//   edge_cnt out  CNT_W  rising edges of clk_out seen in the clk domain (wraps)
`timescale 1ns/1ps
module ring_osc #(
    parameter int  NO_STAGES    = 3,
    parameter real INV_DELAY_ns = 1.0,
    parameter int  CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             clk_out,
    output logic [CNT_W-1:0] edge_cnt
);

    if (((NO_STAGES % 2) == 0) || (NO_STAGES < 3)) begin : g_bad_stages
        $fatal(1, "ring_osc: NO_STAGES must be odd and >= 3");
    end

    logic                 kill_q = 1'b0;
    logic                 s1_q   = 1'b0;
    logic                 s2_q   = 1'b0;
    logic                 s3_q   = 1'b0;
    logic [CNT_W-1:0]     cnt_q  = '0;
    logic [CNT_W-1:0]     cnt_d;
    logic                 ring_en;
    logic [NO_STAGES-1:0] n;

    assign ring_en = en & ~kill_q;

    for (genvar i = 0; i < NO_STAGES; i++) begin : g_stage
        // Alternating start pattern: the ring is stable and clk_out = 0 from time zero.
        logic        node_q = ((i % 2) == 1);
        logic        stage_in;
        int unsigned gen_q  = 0;

        if (i == 0) begin : g_head
            assign stage_in = ring_en & ~n[NO_STAGES-1];
        end else begin : g_tail
            assign stage_in = ~n[i-1];
        end

        // Inertial delay: every input change restarts the window, so a pending update
        // is applied only if the input stayed put for a full stage delay. Pulses
        // narrower than one stage never reach the output.
        always @(stage_in) begin
            gen_q = gen_q + 1;
            fork
                automatic int unsigned tag = gen_q;
                begin
                    #(INV_DELAY_ns);
                    if (tag == gen_q) node_q = stage_in;
                end
            join_none
        end

        assign n[i] = node_q;
    end

    assign clk_out = n[NO_STAGES-1];

    // Count a rising edge once the synchronised level goes 0 -> 1.
    always_comb begin
        cnt_d = cnt_q;
        if (s2_q && !s3_q) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        kill_q <= rst;
        if (rst) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            s3_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q  <= clk_out;
            s2_q  <= s1_q;
            s3_q  <= s2_q;
            cnt_q <= cnt_d;
        end
    end

    assign edge_cnt = cnt_q;

endmodule

// File: tb/tb_ring_osc.sv
// tb/tb_ring_osc.sv - self-checking bench for ring_osc
`timescale 1ns/1ps
module tb_ring_osc;

    int n_checks = 0;
    int n_fail   = 0;

    // Default ring, clk idle: start/stop timing.
    logic        clk_idle = 1'b0;
    logic        rst_def  = 1'b0;
    logic        en_def   = 1'b0;
    logic        clk_out_def;
    logic [15:0] edge_cnt_def;

    // Default ring held disabled.
    logic        rst_idle = 1'b0;
    logic        en_idle  = 1'b0;
    logic        clk_out_idle;
    logic [15:0] edge_cnt_idle;

    // 5-stage, 10 ns rings on a 100 MHz reference clock.
    logic        clk100  = 1'b0;
    logic        rst_big = 1'b0;
    logic        en_big  = 1'b0;
    logic        clk_out_big;
    logic [15:0] edge_cnt_big;
    logic        clk_out_wrap;
    logic [1:0]  edge_cnt_wrap;

    ring_osc u_def (
        .clk(clk_idle), .rst(rst_def), .en(en_def),
        .clk_out(clk_out_def), .edge_cnt(edge_cnt_def)
    );

    ring_osc u_idle (
        .clk(clk_idle), .rst(rst_idle), .en(en_idle),
        .clk_out(clk_out_idle), .edge_cnt(edge_cnt_idle)
    );

    ring_osc #(.NO_STAGES(5), .INV_DELAY_ns(10.0), .CNT_W(16)) u_big (
        .clk(clk100), .rst(rst_big), .en(en_big),
        .clk_out(clk_out_big), .edge_cnt(edge_cnt_big)
    );

    ring_osc #(.NO_STAGES(5), .INV_DELAY_ns(10.0), .CNT_W(2)) u_wrap (
        .clk(clk100), .rst(rst_big), .en(en_big),
        .clk_out(clk_out_wrap), .edge_cnt(edge_cnt_wrap)
    );

    always #5 clk100 = ~clk100;

    // Scoreboard: expected edge times are queued with the stimulus, observed ones by monitors.
    realtime exp_rise_q[$];
    realtime exp_fall_q[$];
    realtime obs_rise_q[$];
    realtime obs_fall_q[$];
    realtime big_rise_q[$];
    realtime big_last_rise = 0.0;
    int      idle_rises    = 0;
    int      idle_x_seen   = 0;
    realtime kill_t;
    realtime release_t;

    always @(posedge clk_out_def) obs_rise_q.push_back($realtime);
    always @(negedge clk_out_def) obs_fall_q.push_back($realtime);
    always @(posedge clk_out_idle) idle_rises++;
    always @(clk_out_idle) if ($isunknown(clk_out_idle)) idle_x_seen++;
    always @(posedge clk_out_big) begin
        big_last_rise = $realtime;
        big_rise_q.push_back($realtime);
    end

    task automatic wait_until(input realtime t);
        if ($realtime < t) #(t - $realtime);
    endtask

    task automatic test_reset;
        wait_until(0.5);
        n_checks++;
        if ({clk_out_def, clk_out_idle, clk_out_big, clk_out_wrap} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_clk_out: got %b required 0000",
                     {clk_out_def, clk_out_idle, clk_out_big, clk_out_wrap});
        end
        n_checks++;
        if (edge_cnt_def !== 16'd0 || edge_cnt_idle !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_cnt_def: got %0d/%0d required 0/0", edge_cnt_def, edge_cnt_idle);
        end
        n_checks++;
        if (edge_cnt_big !== 16'd0 || edge_cnt_wrap !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_cnt_big: got %0d/%0d required 0/0", edge_cnt_big, edge_cnt_wrap);
        end
        wait_until(1.0);
        en_big = 1'b1;
    endtask

    task automatic check_edges(input string name);
        realtime e, o;
        while (exp_rise_q.size() > 0) begin
            e = exp_rise_q.pop_front();
            n_checks++;
            if (obs_rise_q.size() == 0) begin
                n_fail++;
                $display("FAIL %s_rise: got no edge required rise at %0.3f ns", name, e);
            end else begin
                o = obs_rise_q.pop_front();
                if ((o - e > 0.001) || (e - o > 0.001)) begin
                    n_fail++;
                    $display("FAIL %s_rise: got %0.3f ns required %0.3f ns", name, o, e);
                end
            end
        end
        while (exp_fall_q.size() > 0) begin
            e = exp_fall_q.pop_front();
            n_checks++;
            if (obs_fall_q.size() == 0) begin
                n_fail++;
                $display("FAIL %s_fall: got no edge required fall at %0.3f ns", name, e);
            end else begin
                o = obs_fall_q.pop_front();
                if ((o - e > 0.001) || (e - o > 0.001)) begin
                    n_fail++;
                    $display("FAIL %s_fall: got %0.3f ns required %0.3f ns", name, o, e);
                end
            end
        end
        n_checks++;
        if (obs_rise_q.size() != 0 || obs_fall_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_extra: got %0d rises %0d falls unexpected required 0 0",
                     name, obs_rise_q.size(), obs_fall_q.size());
            obs_rise_q.delete();
            obs_fall_q.delete();
        end
    endtask

    task automatic test_start;
        wait_until(10.0);
        en_def = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_rise_q.push_back(13.0 + 6.0 * k);
            exp_fall_q.push_back(16.0 + 6.0 * k);
        end
        wait_until(14.5);
        n_checks++;
        if (clk_out_def !== 1'b1) begin
            n_fail++;
            $display("FAIL start_high: got %b required 1", clk_out_def);
        end
        wait_until(17.5);
        n_checks++;
        if (clk_out_def !== 1'b0) begin
            n_fail++;
            $display("FAIL start_low: got %b required 0", clk_out_def);
        end
        wait_until(35.0);
        check_edges("start");
    endtask

    task automatic test_stop;
        exp_rise_q.push_back(37.0);
        exp_fall_q.push_back(40.0);
        wait_until(40.0);
        en_def = 1'b0;
        wait_until(46.0);
        n_checks++;
        if (clk_out_def !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_settle: got %b required 0", clk_out_def);
        end
        wait_until(59.5);
        n_checks++;
        if (clk_out_def !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_hold: got %b required 0", clk_out_def);
        end
        check_edges("stop");
        wait_until(60.0);
        en_def = 1'b1;
        exp_rise_q.push_back(63.0);
        wait_until(64.0);
        check_edges("restart");
    endtask

    task automatic test_idle;
        wait_until(200.0);
        n_checks++;
        if (idle_rises != 0 || clk_out_idle !== 1'b0 || idle_x_seen != 0) begin
            n_fail++;
            $display("FAIL idle: got rises=%0d out=%b x=%0d required 0/0/0",
                     idle_rises, clk_out_idle, idle_x_seen);
        end
    endtask

    task automatic test_free_count;
        wait_until(200.5);
        n_checks++;
        if (edge_cnt_big !== 16'd2) begin
            n_fail++;
            $display("FAIL free_count: got %0d required 2", edge_cnt_big);
        end
        n_checks++;
        if (edge_cnt_wrap !== 2'd2) begin
            n_fail++;
            $display("FAIL free_count_wrap: got %0d required 2", edge_cnt_wrap);
        end
    endtask

    task automatic test_kill;
        @(negedge clk100);
        rst_big = 1'b1;
        @(posedge clk100);
        kill_t = $realtime;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk100);
            n_checks++;
            if (edge_cnt_big !== 16'd0 || edge_cnt_wrap !== 2'd0) begin
                n_fail++;
                $display("FAIL kill_cnt_cycle%0d: got %0d/%0d required 0/0",
                         c, edge_cnt_big, edge_cnt_wrap);
            end
        end
        wait_until(kill_t + 100.5);
        n_checks++;
        if (clk_out_big !== 1'b0 || clk_out_wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL kill_settle: got %b%b required 00", clk_out_big, clk_out_wrap);
        end
        wait_until(kill_t + 110.0);
        n_checks++;
        if (big_last_rise > kill_t + 50.001) begin
            n_fail++;
            $display("FAIL kill_last_rise: got %0.3f ns required <= %0.3f ns",
                     big_last_rise, kill_t + 50.0);
        end
        n_checks++;
        if (clk_out_big !== 1'b0 || edge_cnt_big !== 16'd0) begin
            n_fail++;
            $display("FAIL kill_hold: got out=%b cnt=%0d required 0/0", clk_out_big, edge_cnt_big);
        end
        @(negedge clk100);
        rst_big = 1'b0;
        big_rise_q.delete();
        @(posedge clk100);
        release_t = $realtime;
    endtask

    task automatic test_count;
        realtime o;
        wait_until(release_t + 600.5);
        n_checks++;
        if (edge_cnt_wrap < 2'd1 || edge_cnt_wrap > 2'd3) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d required 2 +/- 1", edge_cnt_wrap);
        end
        n_checks++;
        if (big_rise_q.size() == 0) begin
            n_fail++;
            $display("FAIL restart_first_rise: got no edge required %0.3f ns", release_t + 50.0);
        end else begin
            o = big_rise_q.pop_front();
            if ((o - release_t - 50.0 > 0.001) || (release_t + 50.0 - o > 0.001)) begin
                n_fail++;
                $display("FAIL restart_first_rise: got %0.3f ns required %0.3f ns",
                         o, release_t + 50.0);
            end
        end
        wait_until(release_t + 1000.5);
        n_checks++;
        if (edge_cnt_big < 16'd9 || edge_cnt_big > 16'd11) begin
            n_fail++;
            $display("FAIL edge_count: got %0d required 10 +/- 1", edge_cnt_big);
        end
    endtask

    initial begin
        test_reset;
        test_start;
        test_stop;
        test_idle;
        test_free_count;
        test_kill;
        test_count;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
